adc_frame_receiver: RTL
=======================

Name: adc_frame_receiver

Overview:
FPGA-side receiver for the on-chip shared-counter ADC output stream. The chip emits 8-bit samples with a qualifying `update` strobe: 128 consecutive samples, channel 0 first, then an idle gap, every 311-clock conversion period. This block reassembles each burst into a 128-byte frame in a ping-pong buffer. It hands completed frames to a downstream consumer (host link / logger) through a ready/ack handshake and a synchronous read port.

Parameters:
- NUM_CH, 128, samples per frame; must be a power of two.
- DATA_W, 8, sample width.
- IN_REG, 1, number of input register stages on `adc_data`/`adc_update`, 0..2.

Ports:
- clk  input  1  system clock, same clock that drives the chip.
- n_reset  input  1  asynchronous, active-low reset.
- enable  input  1  capture enable; when low, no new frame starts.
- adc_data  input  DATA_W  sample bus from the chip.
- adc_update  input  1  sample-valid strobe from the chip.
- rd_addr  input  log2(NUM_CH)  channel index to read from the held frame.
- rd_data  output  DATA_W  sample at `rd_addr`; 1-cycle latency.
- frame_ready  output  1  a complete frame is held for the consumer.
- frame_ack  input  1  one-cycle pulse; consumer releases the held frame.
- frame_id  output  16  sequence number of the held frame.
- frame_drop  output  1  one-cycle pulse: a complete frame was discarded.
- frame_err  output  1  one-cycle pulse: a short or long burst was detected.
- drop_count  output  16  saturating count of dropped frames.

Behaviour:
- Reset values: `rd_data` 0, `frame_ready` 0, `frame_id` 0, `frame_drop` 0, `frame_err` 0, `drop_count` 0. FSM in IDLE. Write bank 0, held bank 1. Buffer contents are undefined.
- Input stage: `IN_REG` flops on data and strobe. All timing below refers to the registered signals.
- FSM states:
  - IDLE: wait for the `adc_update` rising edge (current 1, previous 0) with `enable`=1.
    - On the edge, write sample to index 0, `idx`<=1, go to CAPTURE.
    - An `update` that is already high when leaving reset, or when `enable` rises mid-burst, is not an edge. Wait for the next rising edge.
  - CAPTURE: each cycle with `update`=1, write sample at `idx`, `idx`++.
    - After writing index NUM_CH-1, go to COMMIT.
    - If `update` falls before then: pulse `frame_err`, discard the partial frame, go to IDLE.
  - COMMIT (1 cycle), completed frame in the write bank:
    - If `frame_ready`=0: swap banks, `frame_ready`<=1, `frame_id`<=`frame_id`+1 (wraps at 16 bits). The first frame after reset has id 1.
    - If `frame_ready`=1: keep banks unchanged, pulse `frame_drop`, `drop_count`++ (saturates at 0xFFFF). The write bank is reused.
    - In both cases go to TAIL.
  - TAIL: wait for `update`=0, then go to IDLE.
    - Any `update`=1 seen in TAIL immediately following the NUM_CH-th sample (burst longer than NUM_CH) pulses `frame_err` once. Extra samples are ignored and never written.
- Handshake:
  - `frame_ack` while `frame_ready`=1 clears `frame_ready` on the next cycle.
  - `frame_ack` while `frame_ready`=0 is ignored.
  - `frame_ack` in the same cycle as COMMIT: the ack is applied first, then COMMIT sees ready=0 and swaps. No drop occurs.
  - The held bank is never written while `frame_ready`=1.
- Read port: `rd_data` <= held_bank[`rd_addr`] every cycle, regardless of `frame_ready`. Infer block or distributed RAM with a registered output.
- `enable` low during CAPTURE: finish the current burst normally. `enable` is sampled only in IDLE.
- Reset mid-frame: returns everything to the reset state. The held frame is lost.
- End-to-end latency: `frame_ready` rises 2 cycles after the last sample is registered (write, then COMMIT).

Optional Feature:
- Macro: ADC_FRAME_SUM_EN.
- Defined:
  - Adds output port `frame_sum` (DATA_W+log2(NUM_CH) bits, 15 by default): the unsigned sum of all samples of the held frame.
  - The sum is accumulated during CAPTURE and cleared on the burst rising edge.
  - It is latched into `frame_sum` only on a COMMIT that swaps. Reset value is 0.
- Undefined: no port and no accumulator logic.

Test Plan:
- Nominal (IN_REG=1): 128-cycle `update` burst with data = channel index (0..127), 183-cycle gap, then `frame_ack`.
  - `frame_ready`=1 two cycles after the last sample; `frame_id`=1; `rd_addr`=37 returns 37 one cycle later.
  - With ADC_FRAME_SUM_EN: `frame_sum`=8128.
- Overrun: three bursts with no ack.
  - Frame 1 held; frames 2 and 3 dropped; `frame_drop` pulsed twice; `drop_count`=2.
  - Held data is still frame 1 and `frame_id` stays 1.
- Ack coincident with COMMIT of frame 2: no drop; `frame_ready` stays 1; `frame_id`=2; read returns frame 2 data.
- Short burst of 100 samples: `frame_err` pulses once; no `frame_ready`; the next full burst yields `frame_id`=1.
- Long burst of 130 samples: frame commits with the first 128 samples; `frame_err` pulses once; samples 128 and 129 are absent from the buffer.
- Reset asserted at sample 60 of a burst with `update` still high after release: no capture until the next rising edge; outputs read their reset values.

Source files
------------

// File: rtl/adc_frame_receiver.sv
// Reassembles ADC sample bursts into NUM_CH-sample frames in a ping-pong buffer; optional ADC_FRAME_SUM_EN adds frame_sum.
// Latency: frame_ready 2 cycles after last registered sample; consumer backpressure via frame_ack, overruns drop the new frame.
module adc_frame_receiver #(
    parameter int NUM_CH = 128,
    parameter int DATA_W = 8,
    parameter int IN_REG = 1
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      enable,
    input  logic [DATA_W-1:0]         adc_data,
    input  logic                      adc_update,
    input  logic [$clog2(NUM_CH)-1:0] rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      frame_ready,
    input  logic                      frame_ack,
    output logic [15:0]               frame_id,
    output logic                      frame_drop,
    output logic                      frame_err,
    output logic [15:0]               drop_count
`ifdef ADC_FRAME_SUM_EN
    ,
    output logic [DATA_W+$clog2(NUM_CH)-1:0] frame_sum
`endif
);

    localparam int AW = $clog2(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_COMMIT, S_TAIL} state_t;

    logic              upd_r;
    logic [DATA_W-1:0] dat_r;
    logic              upd_prev;
    state_t            state, state_nxt;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     wr_idx;
    logic              wr_bank;
    logic              we;
    logic              start;
    logic              commit;
    logic              err_nxt;
    logic              ready_eff;
    logic [DATA_W-1:0] mem [2*NUM_CH];

    // Strobe stages reset high so an update already asserted at reset release is not an edge.
    generate
        if (IN_REG == 0) begin : g_noreg
            assign upd_r = adc_update;
            assign dat_r = adc_data;
        end else begin : g_reg
            logic [IN_REG-1:0] upd_sr;
            logic [DATA_W-1:0] dat_sr [IN_REG];

            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    upd_sr <= '1;
                    for (int i = 0; i < IN_REG; i++) dat_sr[i] <= '0;
                end else begin
                    upd_sr[0] <= adc_update;
                    dat_sr[0] <= adc_data;
                    for (int i = 1; i < IN_REG; i++) begin
                        upd_sr[i] <= upd_sr[i-1];
                        dat_sr[i] <= dat_sr[i-1];
                    end
                end
            end

            assign upd_r = upd_sr[IN_REG-1];
            assign dat_r = dat_sr[IN_REG-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= S_IDLE;
            upd_prev <= 1'b1;
        end else begin
            state    <= state_nxt;
            upd_prev <= upd_r;
        end
    end

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        wr_idx    = idx;
        start     = 1'b0;
        commit    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && upd_r && !upd_prev) begin
                    we        = 1'b1;
                    wr_idx    = '0;
                    start     = 1'b1;
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (upd_r) begin
                    we = 1'b1;
                    if (idx == AW'(NUM_CH - 1)) state_nxt = S_COMMIT;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_COMMIT: begin
                // A strobe here is the sample right after the last one: the burst is too long.
                commit    = 1'b1;
                err_nxt   = upd_r;
                state_nxt = S_TAIL;
            end
            S_TAIL: begin
                if (!upd_r) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Ack is applied before a coincident commit, so that commit swaps instead of dropping.
    assign ready_eff = frame_ready & ~frame_ack;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            idx         <= '0;
            wr_bank     <= 1'b0;
            frame_ready <= 1'b0;
            frame_id    <= '0;
            frame_drop  <= 1'b0;
            frame_err   <= 1'b0;
            drop_count  <= '0;
        end else begin
            frame_err   <= err_nxt;
            frame_drop  <= 1'b0;
            frame_ready <= ready_eff | commit;
            if (start)
                idx <= AW'(1);
            else if (state == S_CAPTURE && upd_r)
                idx <= idx + AW'(1);
            if (commit) begin
                if (!ready_eff) begin
                    wr_bank  <= ~wr_bank;
                    frame_id <= frame_id + 16'd1;
                end else begin
                    frame_drop <= 1'b1;
                    if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[{wr_bank, wr_idx}] <= dat_r;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) rd_data <= '0;
        else          rd_data <= mem[{~wr_bank, rd_addr}];
    end

`ifdef ADC_FRAME_SUM_EN
    logic [DATA_W+AW-1:0] acc;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc       <= '0;
            frame_sum <= '0;
        end else begin
            if (start)
                acc <= (DATA_W+AW)'(dat_r);
            else if (state == S_CAPTURE && upd_r)
                acc <= acc + (DATA_W+AW)'(dat_r);
            if (commit && !ready_eff) frame_sum <= acc;
        end
    end
`endif

endmodule
